// File: rtl/ac_couple_sub_if.sv
// Sample stream bundle for the AC-coupling stage.
// Master drives samples; slave returns the coupled stream and mean.
interface ac_couple_sub_if #(
    parameter int DATA_W = 10
);
    logic [DATA_W-1:0] datain;
    logic              in_valid;
    logic              select;
    logic [DATA_W-1:0] dataout;
    logic              out_valid;
    logic [DATA_W-1:0] mean_out;
    logic              mean_upd;

    modport master (
        output datain, in_valid, select,
        input  dataout, out_valid, mean_out, mean_upd
    );

    modport slave (
        input  datain, in_valid, select,
        output dataout, out_valid, mean_out, mean_upd
    );
endinterface

// File: rtl/ac_couple_sub.sv
// Scope AC-coupling: block-mean DC estimate via serial divider,
// subtracted from each live sample and re-centred at mid-scale.
module ac_couple_sub #(
    parameter int DATA_W = 10,
    parameter int WIN    = 640,
    parameter int ACC_W  = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ac_couple_sub_if.slave       bus
);
    localparam int CNT_W = $clog2(WIN);
    localparam int BIT_W = $clog2(ACC_W);
    localparam int AW1   = ACC_W + 1;
    localparam int DW2   = DATA_W + 2;

    localparam logic [CNT_W-1:0]  LAST    = CNT_W'(WIN - 1);
    localparam logic [BIT_W-1:0]  LASTBIT = BIT_W'(ACC_W - 1);
    localparam logic [ACC_W:0]    DIVISOR = AW1'(WIN);
    localparam logic [DATA_W-1:0] HALF    = DATA_W'(1) << (DATA_W - 1);
    localparam logic [DATA_W-1:0] MAXV    = '1;

    typedef enum logic [1:0] {
        ACCUM,
        DIV,
        UPDATE
    } state_t;

    state_t state, state_n;

    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  rem;
    logic [CNT_W-1:0]  cnt;
    logic [BIT_W-1:0]  bitc;
    logic [DATA_W-1:0] mean_q;
    logic [DATA_W-1:0] dout_q;
    logic              oval_q;
    logic              upd_q;

    logic [ACC_W:0]    trial;
    logic [ACC_W:0]    rem_nxt;
    logic              ge;

    logic signed [DW2-1:0] raw;
    logic [DATA_W-1:0]     sat;

    // One restoring-division step; acc doubles as dividend/quotient
    always_comb begin
        trial   = {rem, acc[ACC_W-1]};
        ge      = (trial >= DIVISOR);
        rem_nxt = ge ? (trial - DIVISOR) : trial;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            ACCUM:  if (bus.in_valid && cnt == LAST) state_n = DIV;
            DIV:    if (bitc == LASTBIT) state_n = UPDATE;
            UPDATE: state_n = ACCUM;
            default: state_n = ACCUM;
        endcase
    end

    always_comb begin
        raw = $signed({2'b00, bus.datain})
            - $signed({2'b00, mean_q})
            + $signed({2'b00, HALF});
        sat = '0;
        if (raw < 0)
            sat = '0;
        else if (raw > $signed({2'b00, MAXV}))
            sat = MAXV;
        else
            sat = raw[DATA_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACCUM;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            rem    <= '0;
            cnt    <= '0;
            bitc   <= '0;
            mean_q <= HALF;
            upd_q  <= 1'b0;
        end else begin
            upd_q <= (state == UPDATE);
            unique case (state)
                ACCUM: begin
                    rem  <= '0;
                    bitc <= '0;
                    if (bus.in_valid) begin
                        acc <= acc + {{(ACC_W-DATA_W){1'b0}}, bus.datain};
                        cnt <= cnt + 1'b1;
                    end
                end
                DIV: begin
                    rem  <= rem_nxt[ACC_W-1:0];
                    acc  <= {acc[ACC_W-2:0], ge};
                    bitc <= bitc + 1'b1;
                end
                UPDATE: begin
                    mean_q <= acc[DATA_W-1:0];
                    acc    <= '0;
                    cnt    <= '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
            oval_q <= 1'b0;
        end else begin
            oval_q <= bus.in_valid;
            dout_q <= bus.select ? sat : bus.datain;
        end
    end

    assign bus.dataout   = dout_q;
    assign bus.out_valid = oval_q;
    assign bus.mean_out  = mean_q;
    assign bus.mean_upd  = upd_q;
endmodule

// File: tb/tb_ac_couple_sub.sv
// Directed bench for ac_couple_sub: window means, AC/DC output,
// saturation, gapped valids, mid-divide reset, DIV-time samples.
module tb_ac_couple_sub;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   ntests = 0;
    int   nfail = 0;
    int   n;
    int   pulses;

    ac_couple_sub_if #(.DATA_W(10)) bus ();

    ac_couple_sub #(
        .DATA_W(10),
        .WIN(640),
        .ACC_W(20)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic v, input logic s);
        bus.datain   = 10'(d);
        bus.in_valid = v;
        bus.select   = s;
    endtask

    task automatic do_reset();
        drive(0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic feed(input int d, input int count);
        drive(d, 1'b1, 1'b1);
        repeat (count) cyc();
    endtask

    // Edges until mean_upd is seen; -1 if the bound expires
    task automatic wait_upd(input int bound, output int edges);
        edges = -1;
        for (int i = 1; i <= bound; i++) begin
            cyc();
            if (bus.mean_upd === 1'b1) begin
                edges = i;
                break;
            end
        end
    endtask

    initial begin
        drive(0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #12;
        chk("rst_dataout", 32'(bus.dataout), 0);
        chk("rst_oval", 32'(bus.out_valid), 0);
        chk("rst_mean", 32'(bus.mean_out), 512);
        chk("rst_upd", 32'(bus.mean_upd), 0);

        // Constant 300 in AC mode
        do_reset();
        drive(300, 1'b1, 1'b1);
        cyc();
        chk("c300_first", 32'(bus.dataout), 300);
        chk("c300_oval", 32'(bus.out_valid), 1);
        repeat (639) cyc();
        wait_upd(40, n);
        chk("c300_lat", 32'(n), 21);
        chk("c300_mean", 32'(bus.mean_out), 300);
        chk("c300_oldmean", 32'(bus.dataout), 300);
        cyc();
        chk("c300_upd_1cyc", 32'(bus.mean_upd), 0);
        chk("c300_ac", 32'(bus.dataout), 512);

        // Ramp 0..639 then hold 0
        do_reset();
        for (int i = 0; i < 640; i++) begin
            drive(i, 1'b1, 1'b1);
            cyc();
        end
        drive(0, 1'b1, 1'b1);
        wait_upd(40, n);
        chk("ramp_lat", 32'(n), 21);
        chk("ramp_mean", 32'(bus.mean_out), 319);
        cyc();
        chk("ramp_ac0", 32'(bus.dataout), 193);
        drive(0, 1'b1, 1'b0);
        cyc();
        chk("ramp_dc0", 32'(bus.dataout), 0);
        drive(777, 1'b1, 1'b0);
        cyc();
        chk("ramp_dc777", 32'(bus.dataout), 777);

        // Low-side saturation
        do_reset();
        feed(1000, 640);
        wait_upd(40, n);
        chk("sat_lo_mean", 32'(bus.mean_out), 1000);
        drive(0, 1'b1, 1'b1);
        cyc();
        chk("sat_lo", 32'(bus.dataout), 0);
        drive(700, 1'b1, 1'b1);
        cyc();
        chk("sat_lo_mid", 32'(bus.dataout), 212);

        // High-side saturation
        do_reset();
        feed(10, 640);
        wait_upd(40, n);
        chk("sat_hi_mean", 32'(bus.mean_out), 10);
        drive(1023, 1'b1, 1'b1);
        cyc();
        chk("sat_hi", 32'(bus.dataout), 1023);

        // Gapped valids: 640 valid samples over 1279 cycles
        do_reset();
        n = -1;
        for (int i = 0; i < 1400; i++) begin
            drive(800, (i % 2) == 0, 1'b1);
            cyc();
            chk("gap_oval", 32'(bus.out_valid), 32'((i % 2) == 0));
            if (bus.mean_upd === 1'b1) begin
                n = i;
                break;
            end
        end
        chk("gap_lat", 32'(n), 1299);
        chk("gap_mean", 32'(bus.mean_out), 800);

        // Reset on the 10th DIV cycle
        do_reset();
        feed(200, 640);
        repeat (9) cyc();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dout", 32'(bus.dataout), 0);
        chk("mid_rst_oval", 32'(bus.out_valid), 0);
        chk("mid_rst_mean", 32'(bus.mean_out), 512);
        chk("mid_rst_upd", 32'(bus.mean_upd), 0);
        drive(0, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (bus.mean_upd === 1'b1) pulses++;
        end
        chk("mid_rst_nopulse", 32'(pulses), 0);
        chk("mid_rst_mean2", 32'(bus.mean_out), 512);
        feed(456, 640);
        wait_upd(40, n);
        chk("post_rst_lat", 32'(n), 21);
        chk("post_rst_mean", 32'(bus.mean_out), 456);

        // Samples during DIV/UPDATE are not accumulated
        do_reset();
        feed(100, 640);
        drive(900, 1'b1, 1'b1);
        wait_upd(40, n);
        chk("divs_mean1", 32'(bus.mean_out), 100);
        feed(100, 640);
        wait_upd(40, n);
        chk("divs_lat", 32'(n), 21);
        chk("divs_mean2", 32'(bus.mean_out), 100);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
